spi_write_controller: RTL and testbench
=======================================

Name: spi_write_controller

Overview:
SPI-side write path of the wrapper, and the receive counterpart of the MISO read controller. Deserializes MOSI bits, sampled on iCLK cycles where iEN is high, into bytes, MSB first. Each completed byte is written into the frame buffer at an auto-incrementing address. After a full frame of NUM_BYTES bytes it pulses done and rewinds the address.

Parameters:
AW, 6, address width of oWr_ADDR
NUM_BYTES, 37, bytes per frame (1..2^AW)
START_ADDR, 0, first write address of a frame; START_ADDR+NUM_BYTES-1 must be < 2^AW

Ports:
iCLK  input  1  system clock; all logic on rising edge
iRST  input  1  reset, asynchronous, active-high
iCLR  input  1  synchronous clear; same effect as reset; priority over iEN
iEN  input  1  bit strobe; MOSI sampled on every rising edge where iEN=1
MOSI  input  1  serial data in, MSB first
oWr_EN  output  1  one-cycle buffer write strobe
oWr_ADDR  output  AW  write address, valid while oWr_EN=1
oWr_DATA  output  8  write data, valid while oWr_EN=1
oWr_DONE  output  1  one-cycle pulse after the last byte of a frame is written

Behaviour:
- Reset or iCLR:
  - shift register = 0, bit counter = 0, byte counter = 0
  - oWr_EN = 0, oWr_DATA = 0, oWr_ADDR = START_ADDR, oWr_DONE = 0
  - FSM returns to IDLE
- Bit capture:
  - on each iEN=1 edge, shift_reg <= {shift_reg[6:0], MOSI}
  - bit counter increments 0..7 and wraps to 0
  - iEN=0 holds all state; a partial byte survives gaps in iEN of any length
- Byte complete:
  - the edge sampling bit 7 (counter==7, iEN=1) registers oWr_DATA <= {shift_reg[6:0], MOSI}
  - on that same edge, oWr_EN <= 1
  - oWr_EN is therefore high the cycle after the 8th bit edge, for exactly 1 cycle, independent of iEN
- Back-to-back bits: a new bit may be sampled in the same cycle oWr_EN is high. oWr_DATA and oWr_ADDR are stable for that whole cycle, so there is no overrun and no bytes are dropped.
- Address:
  - oWr_ADDR = START_ADDR + byte counter
  - the byte counter increments on the edge that ends an oWr_EN cycle
  - the address is therefore constant during its strobe and advances afterwards
- FSM states:
  - IDLE: byte counter 0, no bits received yet.
    - IDLE -> RECV on the first iEN=1 edge.
  - RECV: receiving bytes.
    - RECV -> LAST on the edge where oWr_EN=1 and byte counter == NUM_BYTES-1.
    - On that edge the byte counter resets to 0, so oWr_ADDR = START_ADDR.
  - LAST: oWr_DONE=1 for exactly this one cycle.
    - LAST -> RECV if iEN=1 on this edge; that bit is captured as bit 7 of the next frame's byte 0.
    - LAST -> IDLE otherwise.
- oWr_DONE latency: DONE is high the cycle after the last oWr_EN, i.e. 2 cycles after the final bit edge.
- Frames are continuous; wrap-around after NUM_BYTES is automatic with no gap required.
- iCLR mid-byte or mid-frame: partial data is discarded, and no strobe or DONE is emitted for it.
- If iCLR coincides with a pending oWr_EN edge, the clear wins and the strobe is suppressed.
- Reset mid-operation: identical to iCLR, but asynchronous.
- Outputs are all registered; no combinational path from MOSI or iEN to any output.

Decomposition:
- Shared package constants:
  - SPI_BYTE_BITS=8
  - FRAME_BYTES=37
  - FRAME_AW=6
  - FSM state encodings IDLE/RECV/LAST, shared with the read controller so both ends agree on frame length.
- One sub-module: spi_byte_deserializer.
  - Contains the shift register, bit counter and byte-valid pulse generation.
  - Ports: clk, rst, clr, en, sdi, byte[7:0], byte_vld.
  - The top level holds the address/byte counter, FSM and output registers.

Test Plan:
- Reset released, iEN=0 for 20 cycles -> oWr_EN=0, oWr_DONE=0, oWr_ADDR=0, oWr_DATA=0 throughout.
- Continuous iEN=1, MOSI bits 1,0,1,0,0,1,0,1 -> single oWr_EN pulse 1 cycle after the 8th edge, oWr_DATA=8'hA5, oWr_ADDR=0; ADDR=1 on the following cycle.
- Same byte 8'h3C sent with iEN toggling 1/0 every cycle plus a 10-cycle gap after bit 4 -> oWr_DATA=8'h3C, one strobe only.
- 37 continuous bytes 8'h00..8'h24 -> 37 strobes at ADDR 0..36 with DATA==ADDR; oWr_DONE high exactly 1 cycle, 1 cycle after the ADDR=36 strobe; ADDR back to 0. A 38th byte is written at ADDR 0 with no bit lost.
- iCLR asserted after 5 bits of byte 3 -> no strobe; next full byte 8'hFF is written at ADDR 0.
- iRST asserted asynchronously mid-frame (between clock edges) -> outputs go to reset values immediately; subsequent frame behaves as the 37-byte scenario.

Source files
------------

// File: rtl/spi_write_controller_pkg.sv
// Shared frame constants and FSM encoding for the SPI read/write controllers.
// Both ends import this so they agree on byte width and frame length.
package spi_write_controller_pkg;

  localparam int SPI_BYTE_BITS = 8;
  localparam int FRAME_BYTES   = 37;
  localparam int FRAME_AW      = 6;
  localparam int BIT_CW        = $clog2(SPI_BYTE_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_LAST = 2'd2
  } frame_state_e;

endpackage

// File: rtl/spi_write_controller_deserializer.sv
// MSB-first serial-to-parallel converter: shifts one bit per enabled edge and
// emits a registered byte plus a one-cycle valid pulse after the eighth bit.
module spi_byte_deserializer
  import spi_write_controller_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     sdi_i,
  output logic [SPI_BYTE_BITS-1:0] byte_o,
  output logic                     byte_vld_o
);

  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(SPI_BYTE_BITS - 1);

  logic [SPI_BYTE_BITS-1:0] shift_q, shift_d;
  logic [SPI_BYTE_BITS-1:0] byte_q, byte_d;
  logic [BIT_CW-1:0]        cnt_q, cnt_d;
  logic                     vld_q, vld_d;

  always_comb begin
    shift_d = shift_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    if (clr_i) begin
      shift_d = '0;
      byte_d  = '0;
      cnt_d   = '0;
    end else if (en_i) begin
      shift_d = {shift_q[SPI_BYTE_BITS-2:0], sdi_i};
      cnt_d   = cnt_q + BIT_CW'(1);
      // The completing bit bypasses the shift register so the byte is ready one edge earlier.
      if (cnt_q == LAST_BIT) begin
        byte_d = {shift_q[SPI_BYTE_BITS-2:0], sdi_i};
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign byte_o     = byte_q;
  assign byte_vld_o = vld_q;

endmodule

// File: rtl/spi_write_controller.sv
// SPI write path: deserialized MOSI bytes are written to the frame buffer at an
// auto-incrementing address, with a done pulse after each full frame.
module spi_write_controller
  import spi_write_controller_pkg::*;
#(
  parameter int AW         = FRAME_AW,
  parameter int NUM_BYTES  = FRAME_BYTES,
  parameter int START_ADDR = 0
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iCLR,
  input  logic                     iEN,
  input  logic                     MOSI,
  output logic                     oWr_EN,
  output logic [AW-1:0]            oWr_ADDR,
  output logic [SPI_BYTE_BITS-1:0] oWr_DATA,
  output logic                     oWr_DONE
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BYTES - 1);
  localparam logic [AW-1:0] BASE     = AW'(START_ADDR);

  logic [SPI_BYTE_BITS-1:0] byte_s;
  logic                     byte_vld_s;
  logic                     last_byte_s;

  frame_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          done_q, done_d;

  spi_byte_deserializer u_deser (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .clr_i      (iCLR),
    .en_i       (iEN),
    .sdi_i      (MOSI),
    .byte_o     (byte_s),
    .byte_vld_o (byte_vld_s)
  );

  assign last_byte_s = byte_vld_s && (cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (iCLR) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      // The counter advances as the strobe cycle ends, keeping the address stable during it.
      if (byte_vld_s) begin
        if (last_byte_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (iEN) begin
            state_d = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RECV: begin
          state_d = ST_RECV;
        end
        ST_LAST: begin
          if (iEN) begin
            state_d = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (last_byte_s) begin
        state_d = ST_LAST;
      end
    end
    addr_d = BASE + cnt_d;
    done_d = (state_d == ST_LAST);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= BASE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign oWr_EN   = byte_vld_s;
  assign oWr_DATA = byte_s;
  assign oWr_ADDR = addr_q;
  assign oWr_DONE = done_q;

endmodule

// File: tb/tb_spi_write_controller.sv
// Directed bench for spi_write_controller: single bytes, gapped strobes,
// full frames with wrap-around, synchronous clear and asynchronous reset.
module tb_spi_write_controller;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iCLR = 1'b0;
  logic       iEN  = 1'b0;
  logic       MOSI = 1'b0;
  logic       oWr_EN;
  logic [5:0] oWr_ADDR;
  logic [7:0] oWr_DATA;
  logic       oWr_DONE;

  int n_cmp = 0;
  int n_err = 0;

  spi_write_controller dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iCLR     (iCLR),
    .iEN      (iEN),
    .MOSI     (MOSI),
    .oWr_EN   (oWr_EN),
    .oWr_ADDR (oWr_ADDR),
    .oWr_DATA (oWr_DATA),
    .oWr_DONE (oWr_DONE)
  );

  always #5 iCLK = ~iCLK;

  // Drive inputs, take one rising edge, and return 1 time unit after it.
  task automatic step(input logic en, input logic d, input logic clr);
    iEN  = en;
    MOSI = d;
    iCLR = clr;
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_idle_outputs(input logic [5:0] a, input string tag);
    n_cmp++;
    if (oWr_EN !== 1'b0) begin n_err++; $display("FAIL %s_en: got %0b want 0", tag, oWr_EN); end
    n_cmp++;
    if (oWr_DONE !== 1'b0) begin n_err++; $display("FAIL %s_done: got %0b want 0", tag, oWr_DONE); end
    n_cmp++;
    if (oWr_ADDR !== a) begin n_err++; $display("FAIL %s_addr: got %0d want %0d", tag, oWr_ADDR, a); end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [5:0] a, input bit done_first);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, d[i], 1'b0);
      n_cmp++;
      if (oWr_EN !== 1'(i == 0)) begin
        n_err++; $display("FAIL byte_en: byte %0h bit %0d got %0b want %0b", d, i, oWr_EN, (i == 0));
      end
      n_cmp++;
      if (oWr_ADDR !== a) begin
        n_err++; $display("FAIL byte_addr: byte %0h bit %0d got %0d want %0d", d, i, oWr_ADDR, a);
      end
      n_cmp++;
      if (oWr_DONE !== 1'(done_first && i == 7)) begin
        n_err++; $display("FAIL byte_done: byte %0h bit %0d got %0b want %0b", d, i, oWr_DONE, (done_first && i == 7));
      end
      if (i == 0) begin
        n_cmp++;
        if (oWr_DATA !== d) begin n_err++; $display("FAIL byte_data: got %0h want %0h", oWr_DATA, d); end
      end
    end
  endtask

  task automatic run_frame();
    for (int k = 0; k < 37; k++) begin
      send_byte(8'(k), 6'(k), 1'b0);
    end
    send_byte(8'hC3, 6'd0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge iCLK);
    #1;
    check_idle_outputs(6'd0, "rst_held");
    n_cmp++;
    if (oWr_DATA !== 8'h00) begin n_err++; $display("FAIL rst_held_data: got %0h want 00", oWr_DATA); end
    iRST = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, 1'b0);
      check_idle_outputs(6'd0, "rst_idle");
      n_cmp++;
      if (oWr_DATA !== 8'h00) begin n_err++; $display("FAIL rst_idle_data: got %0h want 00", oWr_DATA); end
    end
  endtask

  task automatic test_single_byte();
    send_byte(8'hA5, 6'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_idle_outputs(6'd1, "a5_after");
  endtask

  task automatic test_gapped_byte();
    logic [7:0] d;
    d = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, d[i], 1'b0);
      n_cmp++;
      if (oWr_EN !== 1'(i == 0)) begin n_err++; $display("FAIL gap_en: bit %0d got %0b want %0b", i, oWr_EN, (i == 0)); end
      if (i == 0) begin
        n_cmp++;
        if (oWr_DATA !== 8'h3C) begin n_err++; $display("FAIL gap_data: got %0h want 3c", oWr_DATA); end
        n_cmp++;
        if (oWr_ADDR !== 6'd1) begin n_err++; $display("FAIL gap_addr: got %0d want 1", oWr_ADDR); end
      end else begin
        step(1'b0, ~d[i], 1'b0);
        check_idle_outputs(6'd1, "gap_off");
        if (i == 4) begin
          for (int g = 0; g < 10; g++) begin
            step(1'b0, 1'b1, 1'b0);
            check_idle_outputs(6'd1, "gap_long");
          end
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b0);
      check_idle_outputs(6'd2, "gap_after");
    end
    step(1'b0, 1'b0, 1'b1);
    check_idle_outputs(6'd0, "gap_clr");
  endtask

  task automatic test_frame();
    run_frame();
  endtask

  task automatic test_clear();
    logic [7:0] d;
    d = 8'h33;
    send_byte(8'h11, 6'd1, 1'b0);
    send_byte(8'h22, 6'd2, 1'b0);
    for (int i = 7; i >= 3; i--) begin
      step(1'b1, d[i], 1'b0);
      check_idle_outputs(6'd3, "clr_part");
    end
    step(1'b0, 1'b0, 1'b1);
    check_idle_outputs(6'd0, "clr_mid");
    n_cmp++;
    if (oWr_DATA !== 8'h00) begin n_err++; $display("FAIL clr_mid_data: got %0h want 00", oWr_DATA); end
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check_idle_outputs(6'd0, "clr_pre");
    end
    step(1'b1, 1'b1, 1'b1);
    check_idle_outputs(6'd0, "clr_coinc");
    step(1'b0, 1'b0, 1'b0);
    check_idle_outputs(6'd0, "clr_coinc_next");
    send_byte(8'hFF, 6'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    send_byte(8'h77, 6'd1, 1'b0);
    #2;
    iRST = 1'b1;
    #1;
    check_idle_outputs(6'd0, "arst");
    n_cmp++;
    if (oWr_DATA !== 8'h00) begin n_err++; $display("FAIL arst_data: got %0h want 00", oWr_DATA); end
    #2;
    iRST = 1'b0;
    run_frame();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_gapped_byte();
    test_frame();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
